// File: rtl/port_event_pkg.sv
// Shared definitions for the port event capture slice.
// Port ids, the default timestamp width and the event record layout.
package port_event_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned TS_W_DEFAULT = 16;

  typedef struct packed {
    logic                    port;
    logic [7:0]              data;
    logic [TS_W_DEFAULT-1:0] stamp;
  } port_event_t;

endpackage

// File: rtl/event_fifo.sv
// First-word fall-through FIFO of event records.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   push         write push_data this edge, if there is room (or a pop frees it)
//   push_data    record to store
//   pop          consumer takes the head record; ignored while empty
//   pop_data     head record, all zeros while empty
//   full, empty  occupancy flags
//   count        occupancy, 0..DEPTH
module event_fifo
  import port_event_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = port_event_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/port_event_capture.sv
// Observer for the two 8-bit processor output ports. Every value change is
// captured with a timestamp into a per-port pending slot, then moved into an
// event FIFO (port A first) that a consumer drains over valid/ready.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   port_A, port_B    observed processor ports
//   rd_ready          consumer accepts the head record
//   rd_valid          head record present
//   rd_port/data/stamp head record fields, zero while empty
//   count             FIFO occupancy
//   overflow          sticky, a record was dropped on a full FIFO
//   clr_overflow      clears overflow; a simultaneous drop keeps it set
module port_event_capture
  import port_event_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = TS_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               port_A,
  input  logic [7:0]               port_B,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic                     rd_port,
  output logic [7:0]               rd_data,
  output logic [TS_W-1:0]          rd_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  // Same layout as port_event_t, but sized by this instance's TS_W.
  typedef struct packed {
    logic            port;
    logic [7:0]      data;
    logic [TS_W-1:0] stamp;
  } event_t;

  logic [TS_W-1:0] ts_cnt;
  logic [7:0]      prev_a;
  logic [7:0]      prev_b;
  logic            slot_a_v;
  logic            slot_b_v;
  event_t          slot_a;
  event_t          slot_b;

  logic            chg_a;
  logic            chg_b;
  logic            sel_a;
  logic            sel_b;
  logic            wr_req;
  event_t          wr_rec;
  logic            drop;

  event_t          head;
  logic            fifo_full;
  logic            fifo_empty;

  assign chg_a = (port_A != prev_a);
  assign chg_b = (port_B != prev_b);

  always_comb begin
    sel_a  = slot_a_v;
    sel_b  = !slot_a_v && slot_b_v;
    wr_req = slot_a_v || slot_b_v;
    wr_rec = '0;
    if (sel_a)      wr_rec = slot_a;
    else if (sel_b) wr_rec = slot_b;
  end

  // Full implies non-empty, so rd_ready alone decides whether a pop frees room.
  assign drop = wr_req && fifo_full && !rd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt   <= '0;
      prev_a   <= '0;
      prev_b   <= '0;
      slot_a_v <= 1'b0;
      slot_b_v <= 1'b0;
      slot_a   <= '0;
      slot_b   <= '0;
      overflow <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      prev_a <= port_A;
      prev_b <= port_B;

      // A reload on the same edge as the slot drains takes precedence.
      if (chg_a) begin
        slot_a_v <= 1'b1;
        slot_a   <= '{port: PORT_A, data: port_A, stamp: ts_cnt};
      end else if (sel_a) begin
        slot_a_v <= 1'b0;
      end

      if (chg_b) begin
        slot_b_v <= 1'b1;
        slot_b   <= '{port: PORT_B, data: port_B, stamp: ts_cnt};
      end else if (sel_b) begin
        slot_b_v <= 1'b0;
      end

      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .T     (event_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_req),
    .push_data (wr_rec),
    .pop       (rd_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign rd_valid = !fifo_empty;
  assign rd_port  = head.port;
  assign rd_data  = head.data;
  assign rd_stamp = head.stamp;

endmodule

// File: doc/port_event_capture.md
Name: port_event_capture

Overview:
- Reader/observer for the processor's two 8-bit output ports, port_A and port_B.
- Watches both ports every clock and detects value changes.
- Each change is logged as an event record {port id, new value, timestamp} in an on-chip FIFO.
- A downstream consumer (bench scoreboard, UART dumper or debug bus) drains the FIFO through a valid/ready read interface.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TS_W, 16, timestamp counter width in bits.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- port_A  input  8  processor output port A, synchronous to clk.
- port_B  input  8  processor output port B, synchronous to clk.
- rd_ready  input  1  consumer accepts the head record this cycle.
- rd_valid  output  1  FIFO non-empty; head record presented.
- rd_port  output  1  head record port id: 0 = A, 1 = B.
- rd_data  output  8  head record port value.
- rd_stamp  output  TS_W  head record timestamp.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: at least one event dropped.
- clr_overflow  input  1  clears overflow.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). While reset is high:
  - FIFO empty; rd_valid, rd_port, rd_data, rd_stamp, count, overflow all 0.
  - prev_A = prev_B = 8'h00; both pending slots empty; timestamp counter = 0.
- Timestamp: free-running TS_W counter, +1 on every edge after reset deasserts, wraps modulo 2^TS_W.
- Change detection, per port X:
  - At an edge where port_X != prev_X, load pending slot X with {X, port_X, current counter value}.
  - prev_X <= port_X on every edge.
- Pending slots: one per port.
  - If slot X is already occupied when a new change arrives, the new value and stamp overwrite it (coalesce).
  - Coalescing does not set overflow.
- Arbiter: at most one FIFO write per edge.
  - Slot A has priority over slot B.
  - A slot is cleared on the edge its record is written or dropped.
  - A slot may be written and reloaded on the same edge; the reload wins.
- Latency: change sampled at edge N -> record in FIFO at edge N+1 (uncontended) -> rd_valid high after edge N+1.
  - If A and B change at the same edge N: A is written at N+1, B at N+2.
- Read side (first-word fall-through):
  - rd_* always show the head record when rd_valid = 1; they are 0 when the FIFO is empty.
  - Pop occurs when rd_valid && rd_ready.
  - rd_ready while empty is ignored.
- Full FIFO:
  - Write attempt with no simultaneous pop: record dropped, slot cleared, overflow <= 1.
  - Push and pop on the same edge while full: both occur, count unchanged, no overflow.
  - Push and pop on the same edge while empty: the push is stored; nothing is popped.
- overflow:
  - Cleared by clr_overflow.
  - A new drop on the same edge as clr_overflow leaves overflow = 1 (set wins).
- count: exact occupancy, range 0..DEPTH; FIFO pointers wrap modulo DEPTH.
- Reset asserted mid-operation: all state cleared immediately, including queued and pending records.

Decomposition:
- Package port_event_pkg holds:
  - PORT_A = 1'b0 and PORT_B = 1'b1.
  - typedef struct packed port_event_t {port, data[7:0], stamp[TS_W-1:0]}, with TS_W default constant.
- One natural sub-module: event_fifo.
  - Parameterised synchronous FIFO of port_event_t.
  - Push/pop/full/empty/count, first-word fall-through.
- Change detection, pending slots, arbiter and timestamp stay in the top module.

Test Plan:
- Reset, then hold A = B = 0 for 10 cycles -> rd_valid stays 0, count = 0, overflow = 0.
- A = 0x12 sampled at counter 3, rd_ready = 1 -> one record {0, 0x12, 3} with rd_valid high exactly one cycle; count returns to 0.
- A = 0x55 and B = 0xAA change at the same edge (counter 5), rd_ready = 0 -> records {0, 0x55, 5} then {1, 0xAA, 5}, written on consecutive edges; count = 2.
- DEPTH = 8, rd_ready = 0, A toggles 0x01/0x02 for 12 cycles -> count saturates at 8 and overflow = 1.
  - Reading out gives the first 8 values in order.
  - clr_overflow pulse clears overflow.
- FIFO full with a push and pop on the same edge -> count stays 8, overflow stays 0, head advances by one.
- Assert reset mid-stream with count = 4 and a pending B -> rd_valid = 0 and count = 0 immediately.
  - After release, no stale record appears.
  - Counter restarts, so the first new record has stamp < 5.
